// File: rtl/lcd_expr_pkg.sv
// Shared constants, state encoding and character helpers for the LCD expression writer.
// LCD_EXPR_CLEAR_EN adds a display clear ahead of every redraw.
package lcd_expr_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] HOME_L1  = 8'h80;

    localparam logic [8:0] CH_EQ = 9'h13D;
    localparam logic [8:0] CH_QM = 9'h13F;

    localparam logic [8:0] OP_CH [4] = '{9'h12B, 9'h12D, 9'h12A, 9'h12F};

`ifdef LCD_EXPR_CLEAR_EN
    localparam int REDRAW_LEN = 8;
`else
    localparam int REDRAW_LEN = 7;
`endif

    typedef enum logic [1:0] {
        S_LOAD,
        S_WAIT,
        S_GAP,
        S_IDLE
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] hi;
        logic [3:0] lo;
    } snap_t;

    function automatic logic [8:0] digit_char(input logic [3:0] d);
        return (d < 4'd10) ? (9'h130 + {5'd0, d}) : CH_QM;
    endfunction

endpackage

// File: rtl/lcd_expr_rom.sv
// Combinational byte table: init commands or redraw bytes built from the snapshot.
// LCD_EXPR_CLEAR_EN shifts the redraw by one to send a clear first.
module lcd_expr_rom
    import lcd_expr_pkg::*;
(
    input  logic       init,
    input  logic [3:0] step,
    input  snap_t      snap,
    output logic [8:0] code
);

    logic [3:0] rd;

    always_comb begin
        code = '0;
        rd   = step;
`ifdef LCD_EXPR_CLEAR_EN
        rd   = step - 4'd1;
`endif
        if (init) begin
            case (step)
                4'd0:    code = {1'b0, FUNC_SET};
                4'd1:    code = {1'b0, DISP_ON};
                4'd2:    code = {1'b0, CLEAR};
                4'd3:    code = {1'b0, ENTRY};
                default: code = '0;
            endcase
        end else begin
            case (rd)
                4'd0:    code = {1'b0, HOME_L1};
                4'd1:    code = digit_char(snap.a);
                4'd2:    code = OP_CH[snap.op];
                4'd3:    code = digit_char(snap.b);
                4'd4:    code = CH_EQ;
                4'd5:    code = digit_char(snap.hi);
                4'd6:    code = digit_char(snap.lo);
                default: code = '0;
            endcase
`ifdef LCD_EXPR_CLEAR_EN
            if (step == 4'd0)
                code = {1'b0, CLEAR};
`endif
        end
    end

endmodule

// File: rtl/lcd_expr_writer.sv
// Drives an LCD byte controller: init commands at power-up, then "a op b = rr" redraws.
// Define LCD_EXPR_CLEAR_EN to clear the display before each redraw.
module lcd_expr_writer
    import lcd_expr_pkg::*;
#(
    parameter logic [17:0] DLY_CYCLES = 18'h3FFFE,
    parameter int          INIT_BYTES = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [3:0] iA,
    input  logic [3:0] iB,
    input  logic [1:0] iOP,
    input  logic [3:0] iRES_HI,
    input  logic [3:0] iRES_LO,
    input  logic       iUpdate,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    input  logic       iLCD_Done,
    output logic       oBusy,
    output logic       oReady
);

    localparam logic [17:0] GAP_LAST  = DLY_CYCLES - 18'd1;
    localparam logic [3:0]  INIT_LAST = 4'(INIT_BYTES - 1);
    localparam logic [3:0]  DRAW_LAST = 4'(REDRAW_LEN - 1);

    state_t      state;
    logic [3:0]  step;
    logic [17:0] cnt;
    logic        pending;
    snap_t       snap;
    logic [8:0]  code;
    logic [3:0]  last_step;

    lcd_expr_rom u_rom (
        .init (!oReady),
        .step (step),
        .snap (snap),
        .code (code)
    );

    assign last_step = oReady ? DRAW_LAST : INIT_LAST;
    assign oBusy     = (state != S_IDLE);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= S_LOAD;
            step       <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            snap       <= '0;
            oLCD_DATA  <= '0;
            oLCD_RS    <= 1'b0;
            oLCD_Start <= 1'b0;
            oReady     <= 1'b0;
        end else begin
            // requests outside IDLE collapse into a single pending redraw
            if (iUpdate && state != S_IDLE)
                pending <= 1'b1;
            case (state)
                S_LOAD: begin
                    oLCD_DATA  <= code[7:0];
                    oLCD_RS    <= code[8];
                    oLCD_Start <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (iLCD_Done) begin
                        oLCD_Start <= 1'b0;
                        cnt        <= '0;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (step == last_step) begin
                            step   <= '0;
                            oReady <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            step  <= step + 4'd1;
                            state <= S_LOAD;
                        end
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end
                S_IDLE: begin
                    if (iUpdate || pending) begin
                        pending <= 1'b0;
                        snap    <= '{a: iA, b: iB, op: iOP,
                                     hi: iRES_HI, lo: iRES_LO};
                        state   <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_expr_writer.sv
// Self-checking bench for lcd_expr_writer with a 3-cycle LCD controller model.
// Compile with LCD_EXPR_CLEAR_EN to expect the 8-transfer redraw.
module tb_lcd_expr_writer;

    logic       CLOCK_50 = 1'b0;
    logic       DLY_RST  = 1'b1;
    logic [3:0] iA = '0, iB = '0, iRES_HI = '0, iRES_LO = '0;
    logic [1:0] iOP = '0;
    logic       iUpdate = 1'b0;
    logic       iLCD_Done = 1'b0;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS, oLCD_Start, oBusy, oReady;

    always #10 CLOCK_50 = ~CLOCK_50;

    lcd_expr_writer #(.DLY_CYCLES(18'd4), .INIT_BYTES(4)) dut (
        .iCLK(CLOCK_50), .iRST(DLY_RST),
        .iA(iA), .iB(iB), .iOP(iOP),
        .iRES_HI(iRES_HI), .iRES_LO(iRES_LO),
        .iUpdate(iUpdate),
        .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS),
        .oLCD_Start(oLCD_Start), .iLCD_Done(iLCD_Done),
        .oBusy(oBusy), .oReady(oReady)
    );

    int tests = 0;
    int fails = 0;

    // LCD byte controller: done three cycles after start rises
    int   wcnt = 0;
    logic block_done = 1'b0;
    always @(negedge CLOCK_50) begin
        if (oLCD_Start) begin
            wcnt++;
            iLCD_Done = (wcnt >= 3) && !block_done;
        end else begin
            wcnt = 0;
            iLCD_Done = 1'b0;
        end
    end

    // Transfer monitor
    logic [8:0] cap[$];
    int         gaps[$];
    logic [8:0] exp_q[$];
    int   low_cnt = 0, hold_err = 0;
    int   ready_gap = -1, ready_ncap = -1;
    logic ready_busy = 1'b1, prev_start = 1'b0, prev_ready = 1'b0;
    logic [8:0] prev_byte = '0;
    always @(negedge CLOCK_50) begin
        if (oLCD_Start) begin
            if (!prev_start) begin
                cap.push_back({oLCD_RS, oLCD_DATA});
                gaps.push_back(low_cnt);
            end else if ({oLCD_RS, oLCD_DATA} != prev_byte) begin
                hold_err++;
            end
            low_cnt = 0;
        end else begin
            low_cnt++;
        end
        if (oReady && !prev_ready) begin
            ready_gap  = low_cnt;
            ready_busy = oBusy;
            ready_ncap = cap.size();
        end
        prev_start = oLCD_Start;
        prev_ready = oReady;
        prev_byte  = {oLCD_RS, oLCD_DATA};
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cap.size())
                chk($sformatf("%s_byte%0d", name, i), 32'(cap[i]), 32'(exp_q[i]));
    endtask

    // Reference: ASCII text of the expression, RS=1 for characters
    function automatic logic [8:0] dch(input logic [3:0] d);
        return (d <= 9) ? 9'h100 + 9'(8'h30 + 8'(d)) : 9'h13F;
    endfunction

    task automatic push_redraw(input logic [3:0] a, input logic [1:0] op,
                               input logic [3:0] b, input logic [3:0] hi,
                               input logic [3:0] lo);
        string ops = "+-*/";
`ifdef LCD_EXPR_CLEAR_EN
        exp_q.push_back(9'h001);
`endif
        exp_q.push_back(9'h080);
        exp_q.push_back(dch(a));
        exp_q.push_back(9'h100 | 9'(ops[op]));
        exp_q.push_back(dch(b));
        exp_q.push_back(9'h13D);
        exp_q.push_back(dch(hi));
        exp_q.push_back(dch(lo));
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic pulse_update();
        @(negedge CLOCK_50) iUpdate = 1'b1;
        @(negedge CLOCK_50) iUpdate = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int quiet = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge CLOCK_50);
            if (!oBusy) quiet++;
            else quiet = 0;
            if (quiet >= 12) return;
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_cap(input string name, input int n);
        for (int k = 0; k < 2000; k++) begin
            if (cap.size() >= n) return;
            @(negedge CLOCK_50);
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic set_in(input logic [3:0] a, input logic [1:0] op,
                          input logic [3:0] b, input logic [3:0] hi,
                          input logic [3:0] lo);
        iA = a; iOP = op; iB = b; iRES_HI = hi; iRES_LO = lo;
    endtask

    typedef struct packed {
        logic [3:0] a;
        logic [1:0] op;
        logic [3:0] b;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [5:0][8:0] ch;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{4'd3, 2'd2, 4'd4, 4'd1, 4'd2,
                   {9'h132, 9'h131, 9'h13D, 9'h134, 9'h12A, 9'h133}};
        tbl[1] = '{4'd12, 2'd0, 4'd0, 4'd0, 4'd9,
                   {9'h139, 9'h130, 9'h13D, 9'h130, 9'h12B, 9'h13F}};
        tbl[2] = '{4'd9, 2'd1, 4'd15, 4'd10, 4'd5,
                   {9'h135, 9'h13F, 9'h13D, 9'h13F, 9'h12D, 9'h139}};
        tbl[3] = '{4'd0, 2'd3, 4'd7, 4'd0, 4'd0,
                   {9'h130, 9'h130, 9'h13D, 9'h137, 9'h12F, 9'h130}};

        // reset state
        repeat (3) @(negedge CLOCK_50);
        chk("rst_start", 32'(oLCD_Start), 32'd0);
        chk("rst_data", 32'({oLCD_RS, oLCD_DATA}), 32'd0);
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd1);
        cap.delete(); gaps.delete();

        // init with three collapsed update requests
        set_in(tbl[0].a, tbl[0].op, tbl[0].b, tbl[0].hi, tbl[0].lo);
        DLY_RST = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        pulse_update();
        repeat (6) @(negedge CLOCK_50);
        pulse_update();
        repeat (6) @(negedge CLOCK_50);
        pulse_update();
        chk("init_not_ready_yet", 32'(oReady), 32'd0);
        wait_quiet("init");
        chk("ready_busy_same_edge", 32'(ready_busy), 32'd0);
        chk("ready_after_gap", 32'(ready_gap), 32'd5);
        chk("ready_after_4", 32'(ready_ncap), 32'd4);
        for (int i = 1; i < 4; i++)
            if (i < gaps.size())
                chk($sformatf("init_gap%0d", i), 32'(gaps[i]), 32'd5);
        exp_q.delete();
        push_init();
        push_redraw(tbl[0].a, tbl[0].op, tbl[0].b, tbl[0].hi, tbl[0].lo);
        check_seq("init_one_redraw");

        // table vectors with hand-computed characters
        for (int k = 0; k < 4; k++) begin
            set_in(tbl[k].a, tbl[k].op, tbl[k].b, tbl[k].hi, tbl[k].lo);
            cap.delete();
            pulse_update();
            wait_quiet("tbl");
            exp_q.delete();
`ifdef LCD_EXPR_CLEAR_EN
            exp_q.push_back(9'h001);
`endif
            exp_q.push_back(9'h080);
            for (int i = 0; i < 6; i++) exp_q.push_back(tbl[k].ch[i]);
            check_seq($sformatf("tbl%0d", k));
        end

        // randomized redraws against the reference
        for (int k = 0; k < 12; k++) begin
            set_in(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
            exp_q.delete();
            push_redraw(iA, iOP, iB, iRES_HI, iRES_LO);
            cap.delete();
            pulse_update();
            wait_quiet("rnd");
            check_seq($sformatf("rnd%0d", k));
        end

        // input change mid-redraw, then a long stalled transfer
        begin
            logic [8:0] held;
            int bad = 0;
            set_in(4'd5, 2'd1, 4'd2, 4'd0, 4'd3);
            exp_q.delete();
            push_redraw(4'd5, 2'd1, 4'd2, 4'd0, 4'd3);
            cap.delete();
            pulse_update();
            wait_cap("mid", 3);
            block_done = 1'b1;
            set_in(4'd8, 2'd2, 4'd9, 4'd7, 4'd6);
            held = {oLCD_RS, oLCD_DATA};
            for (int n = 0; n < 100; n++) begin
                @(negedge CLOCK_50);
                if (!oLCD_Start || {oLCD_RS, oLCD_DATA} != held) bad++;
            end
            chk("stall_held", 32'(bad), 32'd0);
            chk("stall_no_new", 32'(cap.size()), 32'd3);
            block_done = 1'b0;
            wait_quiet("mid");
            check_seq("mid_snapshot");
        end

        // update on the cycle the pending flag is consumed is absorbed
        set_in(4'd1, 2'd0, 4'd1, 4'd0, 4'd2);
        exp_q.delete();
        push_redraw(4'd1, 2'd0, 4'd1, 4'd0, 4'd2);
        push_redraw(4'd1, 2'd0, 4'd1, 4'd0, 4'd2);
        cap.delete();
        pulse_update();
        wait_cap("abs", 2);
        pulse_update();
        for (int n = 0; n < 2000 && oBusy; n++) @(negedge CLOCK_50);
        iUpdate = 1'b1;
        @(negedge CLOCK_50) iUpdate = 1'b0;
        wait_quiet("abs");
        check_seq("absorb");

        // reset during WAIT of a redraw
        cap.delete();
        pulse_update();
        wait_cap("rstw", 2);
        chk("rstw_in_wait", 32'(oLCD_Start), 32'd1);
        DLY_RST = 1'b1;
        @(negedge CLOCK_50);
        chk("rstw_start", 32'(oLCD_Start), 32'd0);
        chk("rstw_ready", 32'(oReady), 32'd0);
        chk("rstw_busy", 32'(oBusy), 32'd1);
        DLY_RST = 1'b0;
        cap.delete();
        wait_quiet("rstw");
        exp_q.delete();
        push_init();
        check_seq("rstw_init");
        chk("rstw_ready_end", 32'(oReady), 32'd1);

        chk("hold_stable", 32'(hold_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_expr_writer.md
LCD_EXPR_WRITER -- requirements
Module: lcd_expr_writer

Interface
REQ-001 Parameter DLY_CYCLES, default 18'h3FFFE: idle gap in clock cycles after each completed LCD transfer.
REQ-002 Parameter INIT_BYTES, default 4: number of power-up command bytes sent.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 iCLK  in  1  system clock (CLOCK_50).
REQ-005 iRST  in  1  synchronous active-high reset.
REQ-006 iA  in  4  operand a (decimal digit).
REQ-007 iB  in  4  operand b (decimal digit).
REQ-008 iOP  in  2  operator: 0 +, 1 -, 2 *, 3 /.
REQ-009 iRES_HI, iRES_LO  in  4 each  result tens and units digits.
REQ-010 iUpdate  in  1  single-cycle redraw request.
REQ-011 oLCD_DATA  out  8  byte to the LCD byte controller (its iDATA).
REQ-012 oLCD_RS  out  1  0 command, 1 character (its iRS).
REQ-013 oLCD_Start  out  1  transfer request (its iStart).
REQ-014 iLCD_Done  in  1  transfer complete (its oDone).
REQ-015 oBusy  out  1  high whenever the state is not IDLE.
REQ-016 oReady  out  1  high once the init sequence has finished; stays high until reset.

Function
REQ-017 States: LOAD, WAIT, GAP, IDLE. A step index selects the byte.
REQ-018 Init sequence, in order: 0x038, 0x00C, 0x001, 0x006. RS is bit 8 of each 9-bit entry.
REQ-019 Redraw sequence, in order: 0x080, then chars a, op, b, '=', res_hi, res_lo.
REQ-020 LOAD: on that edge, register the byte into oLCD_DATA/oLCD_RS, set oLCD_Start=1, then go to WAIT.
REQ-021 WAIT: hold oLCD_DATA, oLCD_RS and oLCD_Start=1 until iLCD_Done is sampled high. On that edge, clear oLCD_Start and go to GAP.
REQ-022 GAP: count exactly DLY_CYCLES cycles. Then go to LOAD for the next step, or to IDLE after the last step.
REQ-023 Digit to character mapping: 0-9 map to 9'h130+digit; 10-15 map to 9'h13F ('?').
REQ-024 Operator characters: 9'h12B, 9'h12D, 9'h12A, 9'h12F for op 0-3.
REQ-025 '=' is 9'h13D.
REQ-026 iA, iB, iOP, iRES_HI and iRES_LO are snapshotted on the edge that leaves IDLE. Input changes during a redraw do not alter the bytes sent.
REQ-027 An iUpdate during init or during a redraw sets a pending flag. Multiple such requests collapse into one redraw.
REQ-028 In IDLE, if iUpdate or the pending flag is set, clear the flag, snapshot the inputs and enter LOAD on the next edge.
REQ-029 An iUpdate arriving on the same cycle that the pending flag is consumed is absorbed; no extra redraw is produced.
REQ-030 oLCD_Start is never high in GAP or IDLE.
REQ-031 A new transfer begins only after iLCD_Done has been seen for the previous one.
REQ-032 The GAP counter is 18 bits wide and clears at each GAP entry.

Reset
REQ-033 When iRST is high at an edge, on that edge: oLCD_DATA=0, oLCD_RS=0, oLCD_Start=0, oReady=0, pending=0, counter=0, step=0, state=LOAD of init step 0.
REQ-034 A reset in the middle of a transfer drops oLCD_Start on the same edge and restarts the init sequence from the beginning.
REQ-035 oBusy is 1 directly after reset.

Configuration
REQ-036 The macro LCD_EXPR_CLEAR_EN controls clearing before each redraw.
REQ-037 With LCD_EXPR_CLEAR_EN defined, every redraw begins with 0x001 (clear) before 0x080, for 8 transfers in total.
REQ-038 Without LCD_EXPR_CLEAR_EN, a redraw is exactly 7 transfers.

Structure
REQ-039 Package lcd_expr_pkg holds:
- command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, HOME_L1 0x80);
- the operator character table;
- the '=' and '?' codes;
- the state encoding.
REQ-040 Sub-module lcd_expr_rom is combinational. It maps (init flag, step, snapshot) to a 9-bit byte.

Verification
REQ-041 Bench model: DLY_CYCLES=4; the LCD byte controller is modelled by raising iLCD_Done 3 cycles after oLCD_Start rises.
REQ-042 Reset release -> 4 transfers 0x38, 0x0C, 0x01, 0x06 (RS=0), each followed by 4 gap cycles. oReady rises on the IDLE entry; oBusy falls on that same edge.
REQ-043 a=3, op=2, b=4, res=1,2, pulse iUpdate -> 0x080 then chars 0x33, 0x2A, 0x34, 0x3D, 0x31, 0x32 with RS=1.
REQ-044 a=12 (out of range) -> the char for a is 0x3F.
REQ-045 Three iUpdate pulses during init -> exactly one redraw follows init.
REQ-046 Change iA in the middle of a redraw -> bytes still match the snapshot. Then hold iLCD_Done low for 100 cycles -> oLCD_Start stays 1 and DATA is stable.
REQ-047 Assert iRST while in WAIT of a redraw -> oLCD_Start=0 on that edge, and init restarts with 0x38. Run with and without LCD_EXPR_CLEAR_EN -> 8 vs 7 redraw transfers.
